// File: rtl/sample_circuit_pkg.sv
// sample_circuit_pkg: shared widths, default truth table and table evaluator for sample_circuit
package sample_circuit_pkg;
  localparam int IDX_W = 5;
  localparam int TT_W = 32;
  localparam logic [TT_W-1:0] TT_DEFAULT = 32'h559A9A9A;
  function automatic logic sc_eval(input logic [IDX_W-1:0] idx, input logic [TT_W-1:0] tt);
    return tt[idx];
  endfunction
endpackage

// File: rtl/sample_circuit_core.sv
// sample_circuit_core: combinational truth-table lookup of {A,B,C,D,E}; table port only with SAMPLE_CIRCUIT_LUT_EN
module sample_circuit_core
  import sample_circuit_pkg::*;
(
  input  logic            A,
  input  logic            B,
  input  logic            C,
  input  logic            D,
  input  logic            E,
`ifdef SAMPLE_CIRCUIT_LUT_EN
  input  logic [TT_W-1:0] tt,
`endif
  output logic            f
);
`ifdef SAMPLE_CIRCUIT_LUT_EN
  assign f = sc_eval({A, B, C, D, E}, tt);
`else
  assign f = sc_eval({A, B, C, D, E}, TT_DEFAULT);
`endif
endmodule

// File: rtl/sample_circuit.sv
// sample_circuit: ((A&B)|(C&~D))^E with optional output register; SAMPLE_CIRCUIT_LUT_EN makes the table writable
module sample_circuit
  import sample_circuit_pkg::*;
#(
  parameter bit   OUT_REG = 1'b1,
  parameter logic RESET_Y = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            A,
  input  logic            B,
  input  logic            C,
  input  logic            D,
  input  logic            E,
`ifdef SAMPLE_CIRCUIT_LUT_EN
  input  logic            tt_wr,
  input  logic [TT_W-1:0] tt_data,
`endif
  output logic            Y
);
  logic f;
`ifdef SAMPLE_CIRCUIT_LUT_EN
  logic [TT_W-1:0] tt_d, tt_q;
  always_comb tt_d = rst ? TT_DEFAULT : tt_wr ? tt_data : tt_q;
  always_ff @(posedge clk) tt_q <= tt_d;
  sample_circuit_core u_core (.A(A), .B(B), .C(C), .D(D), .E(E), .tt(tt_q), .f(f));
`else
  sample_circuit_core u_core (.A(A), .B(B), .C(C), .D(D), .E(E), .f(f));
`endif
  generate
    if (OUT_REG) begin : g_reg
      logic y_d, y_q;
      always_comb y_d = rst ? RESET_Y : f;
      always_ff @(posedge clk) y_q <= y_d;
      assign Y = y_q;
    end else begin : g_comb
      assign Y = f;
    end
  endgenerate
endmodule

// File: tb/tb_sample_circuit.sv
// tb_sample_circuit: directed checks of registered and combinational sample_circuit builds
module tb_sample_circuit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] in_v = '0;
  logic y, y0;
  int checks = 0;
  int errors = 0;
`ifdef SAMPLE_CIRCUIT_LUT_EN
  logic tt_wr = 1'b0;
  logic [31:0] tt_data = '0;
`endif
  always #5 clk = ~clk;
  sample_circuit #(.OUT_REG(1'b1), .RESET_Y(1'b0)) dut (
    .clk(clk), .rst(rst),
    .A(in_v[4]), .B(in_v[3]), .C(in_v[2]), .D(in_v[1]), .E(in_v[0]),
`ifdef SAMPLE_CIRCUIT_LUT_EN
    .tt_wr(tt_wr), .tt_data(tt_data),
`endif
    .Y(y)
  );
  sample_circuit #(.OUT_REG(1'b0), .RESET_Y(1'b0)) dut_comb (
    .clk(clk), .rst(rst),
    .A(in_v[4]), .B(in_v[3]), .C(in_v[2]), .D(in_v[1]), .E(in_v[0]),
`ifdef SAMPLE_CIRCUIT_LUT_EN
    .tt_wr(tt_wr), .tt_data(tt_data),
`endif
    .Y(y0)
  );
  function automatic logic model(input logic [4:0] i);
    return ((i[4] & i[3]) | (i[2] & ~i[1])) ^ i[0];
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic vec(input logic [4:0] v, input logic exp);
    in_v = v;
    tick();
    chk($sformatf("vec_%b", v), y, exp);
  endtask
  initial begin
    #1;
    rst = 1'b1;
    in_v = 5'b11111;
    tick();
    chk("rst_cyc1", y, 1'b0);
    tick();
    chk("rst_cyc2", y, 1'b0);
    rst = 1'b0;
    #2;
    chk("rst_release_hold", y, 1'b0);
    tick();
    chk("post_rst_11111", y, model(5'b11111));
    vec(5'b00000, 1'b0);
    vec(5'b00001, 1'b1);
    vec(5'b00010, 1'b0);
    vec(5'b00101, 1'b0);
    vec(5'b01010, 1'b0);
    vec(5'b10101, 1'b0);
    vec(5'b11000, 1'b1);
    vec(5'b10011, 1'b1);
    vec(5'b01111, 1'b1);
    for (int i = 0; i < 32; i++) begin
      in_v = 5'(i);
      tick();
      chk($sformatf("sweep_%0d", i), y, model(5'(i)));
    end
    in_v = 5'b11000;
    tick();
    chk("pre_mid_rst", y, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst", y, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_mid_rst", y, 1'b1);
`ifdef SAMPLE_CIRCUIT_LUT_EN
    in_v = 5'b00000;
    tt_wr = 1'b1;
    tt_data = 32'h0000_0001;
    tick();
    chk("lut_write_edge_old", y, 1'b0);
    tt_wr = 1'b0;
    tick();
    chk("lut_new_00000", y, 1'b1);
    in_v = 5'b00001;
    tick();
    chk("lut_new_00001", y, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("lut_rst_default_00001", y, 1'b1);
    in_v = 5'b00001;
`endif
    in_v = 5'b00000;
    #1;
    chk("comb_e0", y0, 1'b0);
    in_v = 5'b00001;
    #1;
    chk("comb_e1", y0, 1'b1);
    in_v = 5'b00000;
    #1;
    chk("comb_e0_again", y0, 1'b0);
    in_v = 5'b11000;
    #1;
    chk("comb_11000", y0, 1'b1);
    rst = 1'b1;
    #1;
    chk("comb_rst_no_effect", y0, 1'b1);
    tick();
    chk("comb_rst_after_edge", y0, 1'b1);
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
